algo_tick_scheduler: RTL and testbench

- Sequences the market-data tick stream into the combinational `algo` decision block and turns its out1/out2 decisions into a handshaked order stream.
- Buffers incoming (time_, price_) ticks and presents one tick at a time to `algo` as registered, stable inputs.
- Waits a fixed settle window, samples the decision, then rate-limits issued orders with a cooldown.
- Sits between the tick source (testbench/feed) and the order sink.

---
 rtl/algo_tick_scheduler_pkg.sv | 17 +
 rtl/algo_tick_fifo.sv | 48 ++++
 rtl/algo_tick_scheduler.sv | 173 +++++++++++++++++
 tb/tb_algo_tick_scheduler.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/algo_tick_scheduler_pkg.sv
// Shared types and constants for the tick scheduler: FSM state
// encoding, order side encoding and the default data width.
package algo_tick_scheduler_pkg;

   localparam int DATA_W_DEF = 32;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EVAL  = 2'd1,
      S_ISSUE = 2'd2,
      S_COOL  = 2'd3
   } state_t;

   localparam logic SIDE_BUY  = 1'b1;
   localparam logic SIDE_SELL = 1'b0;

endpackage

// File: rtl/algo_tick_fifo.sv
// Tick FIFO: DEPTH entries of W bits, no bypass.
// Ports: push/wdata in, pop in, full/empty out, head = oldest entry.
module algo_tick_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] wdata,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output logic [W-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   // Extra MSB on each pointer tells full from empty.
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [W-1:0] mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign head  = mem[rd_ptr[AW-1:0]];

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/algo_tick_scheduler.sv
// Feeds buffered ticks one at a time into the algo block, samples
// its buy/sell decision after a settle window and issues rate-limited
// orders on a valid/ready stream.
// Ports: tick_* (input stream), algo_* (algo block I/O),
// order_* (output stream), busy, stale_cnt, conflict_cnt.
module algo_tick_scheduler
   import algo_tick_scheduler_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int DEPTH       = 4,
   parameter int EVAL_CYCLES = 2,
   parameter int COOLDOWN    = 3,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              tick_valid,
   output logic              tick_ready,
   input  logic [DATA_W-1:0] tick_time,
   input  logic [DATA_W-1:0] tick_price,
   output logic [DATA_W-1:0] algo_time,
   output logic [DATA_W-1:0] algo_price,
   input  logic              algo_out1,
   input  logic              algo_out2,
   output logic              order_valid,
   input  logic              order_ready,
   output logic              order_side,
   output logic [DATA_W-1:0] order_time,
   output logic [DATA_W-1:0] order_price,
   output logic              busy,
   output logic [CNT_W-1:0]  stale_cnt,
   output logic [CNT_W-1:0]  conflict_cnt
);

   localparam int EW = $clog2(EVAL_CYCLES + 1);
   localparam int CW = $clog2(COOLDOWN + 2);

   state_t              state;
   state_t              state_n;
   logic                full;
   logic                empty;
   logic [2*DATA_W-1:0] head;
   logic [DATA_W-1:0]   head_time;
   logic [DATA_W-1:0]   head_price;
   logic                pop;
   logic                load;
   logic                stale;
   logic                conflict;
   logic                issue;
   logic                side_n;
   logic [DATA_W-1:0]   last_time;
   logic                have_last;
   logic [EW-1:0]       eval_cnt;
   logic [CW-1:0]       cool_cnt;

   algo_tick_fifo #(
      .DEPTH (DEPTH),
      .W     (2 * DATA_W)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (tick_valid && tick_ready),
      .wdata ({tick_time, tick_price}),
      .pop   (pop),
      .full  (full),
      .empty (empty),
      .head  (head)
   );

   assign head_time   = head[2*DATA_W-1:DATA_W];
   assign head_price  = head[DATA_W-1:0];
   assign tick_ready  = !full;
   assign order_valid = (state == S_ISSUE);
   assign busy        = (state != S_IDLE) || !empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n  = state;
      pop      = 1'b0;
      load     = 1'b0;
      stale    = 1'b0;
      conflict = 1'b0;
      issue    = 1'b0;
      side_n   = order_side;
      unique case (state)
         S_IDLE: begin
            if (!empty) begin
               pop = 1'b1;
               if (have_last && head_time <= last_time) begin
                  stale = 1'b1;
               end else begin
                  load    = 1'b1;
                  state_n = S_EVAL;
               end
            end
         end
         S_EVAL: begin
            if (eval_cnt == '0) begin
               unique case (1'b1)
                  algo_out1 && !algo_out2: begin
                     issue   = 1'b1;
                     side_n  = SIDE_BUY;
                     state_n = S_ISSUE;
                  end
                  !algo_out1 && algo_out2: begin
                     issue   = 1'b1;
                     side_n  = SIDE_SELL;
                     state_n = S_ISSUE;
                  end
                  algo_out1 && algo_out2: begin
                     conflict = 1'b1;
                     state_n  = S_IDLE;
                  end
                  default: state_n = S_IDLE;
               endcase
            end
         end
         S_ISSUE: begin
            if (order_ready)
               state_n = (COOLDOWN > 0) ? S_COOL : S_IDLE;
         end
         S_COOL: begin
            if (cool_cnt == '0) state_n = S_IDLE;
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         algo_time    <= '0;
         algo_price   <= '0;
         last_time    <= '0;
         have_last    <= 1'b0;
         eval_cnt     <= '0;
         cool_cnt     <= '0;
         order_side   <= 1'b0;
         order_time   <= '0;
         order_price  <= '0;
         stale_cnt    <= '0;
         conflict_cnt <= '0;
      end else begin
         if (load) begin
            algo_time  <= head_time;
            algo_price <= head_price;
            last_time  <= head_time;
            have_last  <= 1'b1;
            eval_cnt   <= EW'(EVAL_CYCLES - 1);
         end else if (state == S_EVAL && eval_cnt != '0) begin
            eval_cnt <= eval_cnt - 1'b1;
         end
         if (issue) begin
            order_side  <= side_n;
            order_time  <= algo_time;
            order_price <= algo_price;
         end
         if (state == S_ISSUE && order_ready) begin
            cool_cnt <= CW'((COOLDOWN > 0) ? COOLDOWN - 1 : 0);
         end else if (state == S_COOL && cool_cnt != '0) begin
            cool_cnt <= cool_cnt - 1'b1;
         end
         if (stale && stale_cnt != '1)
            stale_cnt <= stale_cnt + 1'b1;
         if (conflict && conflict_cnt != '1)
            conflict_cnt <= conflict_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_algo_tick_scheduler.sv
// Self-checking bench for algo_tick_scheduler: default instance plus
// a second instance with EVAL_CYCLES=1, COOLDOWN=0.
module tb_algo_tick_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        tick_valid = 1'b0;
   logic        tick_ready;
   logic [31:0] tick_time = '0;
   logic [31:0] tick_price = '0;
   logic [31:0] algo_time;
   logic [31:0] algo_price;
   logic        out1, out2;
   logic        order_valid;
   logic        order_ready = 1'b0;
   logic        order_side;
   logic [31:0] order_time;
   logic [31:0] order_price;
   logic        busy;
   logic [15:0] stale_cnt;
   logic [15:0] conflict_cnt;

   logic        tick_valid2 = 1'b0;
   logic        tick_ready2;
   logic [31:0] tick_time2 = '0;
   logic [31:0] tick_price2 = '0;
   logic [31:0] algo_time2;
   logic [31:0] algo_price2;
   logic        out1b, out2b;
   logic        order_valid2;
   logic        order_ready2 = 1'b0;
   logic        order_side2;
   logic [31:0] order_time2;
   logic [31:0] order_price2;
   logic        busy2;
   logic [15:0] stale_cnt2;
   logic [15:0] conflict_cnt2;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // algo model: 200 -> conflict, 300 -> no decision,
   // even -> buy, odd -> sell
   function automatic logic [1:0] decide(input logic [31:0] p);
      if (p == 32'd200)  return 2'b11;
      if (p == 32'd300)  return 2'b00;
      if (!p[0])         return 2'b10;
      return 2'b01;
   endfunction

   assign {out1, out2}   = decide(algo_price);
   assign {out1b, out2b} = decide(algo_price2);

   algo_tick_scheduler dut (
      .clk(clk), .rst_n(rst_n),
      .tick_valid(tick_valid), .tick_ready(tick_ready),
      .tick_time(tick_time), .tick_price(tick_price),
      .algo_time(algo_time), .algo_price(algo_price),
      .algo_out1(out1), .algo_out2(out2),
      .order_valid(order_valid), .order_ready(order_ready),
      .order_side(order_side), .order_time(order_time),
      .order_price(order_price), .busy(busy),
      .stale_cnt(stale_cnt), .conflict_cnt(conflict_cnt)
   );

   algo_tick_scheduler #(.EVAL_CYCLES(1), .COOLDOWN(0)) dut2 (
      .clk(clk), .rst_n(rst_n),
      .tick_valid(tick_valid2), .tick_ready(tick_ready2),
      .tick_time(tick_time2), .tick_price(tick_price2),
      .algo_time(algo_time2), .algo_price(algo_price2),
      .algo_out1(out1b), .algo_out2(out2b),
      .order_valid(order_valid2), .order_ready(order_ready2),
      .order_side(order_side2), .order_time(order_time2),
      .order_price(order_price2), .busy(busy2),
      .stale_cnt(stale_cnt2), .conflict_cnt(conflict_cnt2)
   );

   typedef struct {
      logic        side;
      logic [31:0] t;
      logic [31:0] p;
   } ord_t;

   typedef struct {
      logic [31:0] t;
      logic [31:0] p;
      logic        ord;
      logic        side;
   } vec_t;

   ord_t        sb[$];
   logic [31:0] seen[$];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      n_vec++;
      n_bad++;
      $display("FAIL %s: timed out / unexpected event", name);
   endtask

   // scoreboard and hold-stability monitor
   logic        have_prev = 1'b0;
   logic        prev_side;
   logic [31:0] prev_t, prev_p;
   logic [31:0] prev_at = '0;

   always @(negedge clk) begin
      if (rst_n && algo_time != prev_at && algo_time != 0)
         seen.push_back(algo_time);
      prev_at = algo_time;
      if (!rst_n || !order_valid) begin
         have_prev = 1'b0;
      end else begin
         if (have_prev) begin
            check("hold_side", order_side, prev_side);
            check("hold_time", order_time, prev_t);
            check("hold_price", order_price, prev_p);
         end
         prev_side = order_side;
         prev_t    = order_time;
         prev_p    = order_price;
         have_prev = 1'b1;
         if (order_ready) begin
            if (sb.size() == 0) begin
               fail("sb_unexpected_order");
            end else begin
               ord_t e;
               e = sb.pop_front();
               check("sb_side", order_side, e.side);
               check("sb_time", order_time, e.t);
               check("sb_price", order_price, e.p);
            end
            have_prev = 1'b0;
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      tick_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic push(input logic [31:0] t, input logic [31:0] p);
      bit ok;
      tick_time  = t;
      tick_price = p;
      tick_valid = 1'b1;
      ok = 0;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (tick_ready) begin
            ok = 1;
            break;
         end
      end
      if (!ok) fail("push_timeout");
      @(posedge clk);
      #1 tick_valid = 1'b0;
   endtask

   task automatic expect_ord(input logic s, input logic [31:0] t,
                             input logic [31:0] p);
      ord_t e;
      e.side = s;
      e.t    = t;
      e.p    = p;
      sb.push_back(e);
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         if (!busy) begin
            ok = 1;
            break;
         end
      end
      if (!ok) fail("idle_timeout");
   endtask

   task automatic wait_rise(output int c);
      logic pv;
      bit   ok;
      pv = order_valid;
      ok = 0;
      c  = 0;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (order_valid && !pv) begin
            c  = cyc;
            ok = 1;
            break;
         end
         pv = order_valid;
      end
      if (!ok) fail("rise_timeout");
   endtask

   vec_t        tbl[7];
   logic [31:0] exp_seen[5];

   initial begin
      int t0, r1, r2;
      logic pv2;

      tbl[0] = '{32'd5, 32'd100, 1'b1, 1'b1};
      tbl[1] = '{32'd5, 32'd101, 1'b0, 1'b0};
      tbl[2] = '{32'd4, 32'd102, 1'b0, 1'b0};
      tbl[3] = '{32'd6, 32'd103, 1'b1, 1'b0};
      tbl[4] = '{32'd7, 32'd200, 1'b0, 1'b0};
      tbl[5] = '{32'd8, 32'd300, 1'b0, 1'b0};
      tbl[6] = '{32'd9, 32'd104, 1'b1, 1'b1};
      exp_seen = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd9};

      // reset state
      do_reset();
      @(negedge clk);
      check("rst_tick_ready", tick_ready, 1);
      check("rst_order_valid", order_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_stale", stale_cnt, 0);
      check("rst_conflict", conflict_cnt, 0);
      check("rst_algo_time", algo_time, 0);
      check("rst_order_time", order_time, 0);

      // latency and order spacing with cooldown
      @(posedge clk);
      #1 order_ready = 1'b1;
      expect_ord(1'b1, 32'd10, 32'd100);
      push(32'd10, 32'd100);
      t0 = cyc;
      expect_ord(1'b0, 32'd11, 32'd101);
      push(32'd11, 32'd101);
      wait_rise(r1);
      check("latency_edges", r1 - t0, 3);
      check("first_side", order_side, 1);
      check("first_time", order_time, 10);
      check("first_price", order_price, 100);
      wait_rise(r2);
      check("order_spacing", r2 - r1, 7);
      wait_idle();

      // table: stale drops, conflict, no-decision
      do_reset();
      seen.delete();
      @(posedge clk);
      #1 order_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         if (tbl[i].ord) expect_ord(tbl[i].side, tbl[i].t, tbl[i].p);
         push(tbl[i].t, tbl[i].p);
      end
      wait_idle();
      check("stale_cnt", stale_cnt, 2);
      check("conflict_cnt", conflict_cnt, 1);
      check("tbl_sb_drained", sb.size(), 0);
      check("seen_count", seen.size(), 5);
      for (int i = 0; i < 5; i++) begin
         if (i < seen.size())
            check("seen_algo_time", seen[i], exp_seen[i]);
      end

      // backpressure: six ticks against a stalled sink
      do_reset();
      @(posedge clk);
      #1 order_ready = 1'b0;
      for (int i = 0; i < 6; i++)
         expect_ord(~i[0], 32'd20 + i, 32'd100 + i);
      fork
         begin
            for (int i = 0; i < 6; i++)
               push(32'd20 + i, 32'd100 + i);
         end
         begin
            repeat (12) @(negedge clk);
            check("bp_tick_ready", tick_ready, 0);
            check("bp_order_valid", order_valid, 1);
            check("bp_order_time", order_time, 20);
            @(posedge clk);
            #1 order_ready = 1'b1;
         end
      join
      wait_idle();
      check("bp_sb_drained", sb.size(), 0);

      // reset while an order is pending with ticks buffered
      do_reset();
      @(posedge clk);
      #1 order_ready = 1'b0;
      push(32'd30, 32'd300);
      push(32'd20, 32'd300);
      push(32'd50, 32'd100);
      push(32'd51, 32'd101);
      push(32'd52, 32'd102);
      push(32'd53, 32'd103);
      wait_rise(r1);
      check("pre_rst_stale", stale_cnt, 1);
      check("pre_rst_time", order_time, 50);
      check("pre_rst_busy", busy, 1);
      #2 rst_n = 1'b0;
      sb.delete();
      #1;
      check("mid_rst_valid", order_valid, 0);
      check("mid_rst_ready", tick_ready, 1);
      check("mid_rst_stale", stale_cnt, 0);
      check("mid_rst_conflict", conflict_cnt, 0);
      check("mid_rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      order_ready = 1'b1;
      expect_ord(1'b1, 32'd1, 32'd100);
      push(32'd1, 32'd100);
      wait_idle();
      check("post_rst_sb_drained", sb.size(), 0);
      check("post_rst_stale", stale_cnt, 0);

      // EVAL_CYCLES=1, COOLDOWN=0 instance
      @(posedge clk);
      #1 order_ready2 = 1'b1;
      tick_time2  = 32'd1;
      tick_price2 = 32'd100;
      tick_valid2 = 1'b1;
      @(posedge clk);
      t0 = cyc + 1;
      #1 tick_time2 = 32'd2;
      tick_price2 = 32'd103;
      @(posedge clk);
      #1 tick_valid2 = 1'b0;
      r1 = 0;
      r2 = 0;
      pv2 = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (order_valid2 && !pv2) begin
            if (r1 == 0) begin
               r1 = cyc;
               check("d2_side1", order_side2, 1);
               check("d2_time1", order_time2, 1);
            end else if (r2 == 0) begin
               r2 = cyc;
               check("d2_side2", order_side2, 0);
               check("d2_time2", order_time2, 2);
            end
         end
         pv2 = order_valid2;
      end
      if (r1 == 0 || r2 == 0) fail("d2_orders");
      else begin
         check("d2_latency", r1 - t0, 2);
         check("d2_spacing", r2 - r1, 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
